// File: rtl/target_pkg.sv
// target_pkg: shared state type, LFSR constants and index-width helper for target_engine
package target_pkg;
  typedef enum logic [1:0] {IDLE, GAP, LIT} state_t;
  localparam int N_TARGETS_DEF = 18;
  localparam int LFSR_W = 16;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/target_engine_lfsr16.sv
// lfsr16: 16-bit Fibonacci LFSR, taps 16,14,13,11, loads SEED on reset
module lfsr16 import target_pkg::*; #(
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic [LFSR_W-1:0] q
);
  // shift toward the MSB, XOR of the tap bits feeds bit 0
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= SEED;
    else if (en) q <= {q[LFSR_W-2:0], ^(q & LFSR_TAPS)};
endmodule

// File: rtl/target_engine.sv
// target_engine: lights one pseudo-random target, turns switch edges into one-hot hit / miss pulses
// Optional WRONG_HIT_PENALTY_EN: an edge on a non-lit switch ends the target with wrong_pulse.
module target_engine import target_pkg::*; #(
  parameter int                N_TARGETS       = N_TARGETS_DEF,
  parameter int                LIFETIME_CYCLES = 50_000_000,
  parameter int                GAP_CYCLES      = 12_500_000,
  parameter logic [LFSR_W-1:0] LFSR_SEED       = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_pulse,
  input  logic                 game_active,
  input  logic [N_TARGETS-1:0] sw_in,
  output logic [N_TARGETS-1:0] target_led,
  output logic [N_TARGETS-1:0] hit_pulse,
  output logic                 miss_pulse,
  output logic                 wrong_pulse
);
  localparam int IDX_W = idx_w(N_TARGETS);
  localparam int CNT_MAX = (LIFETIME_CYCLES > GAP_CYCLES) ? LIFETIME_CYCLES : GAP_CYCLES;
  localparam int CNT_W = (CNT_MAX <= 1) ? 1 : $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] LIFE_LAST = CNT_W'(LIFETIME_CYCLES - 1);
  localparam logic [IDX_W-1:0] N_IDX = IDX_W'(N_TARGETS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_TARGETS - 1);
  localparam logic [N_TARGETS-1:0] ONE = {{(N_TARGETS-1){1'b0}}, 1'b1};
`ifdef WRONG_HIT_PENALTY_EN
  localparam logic WRONG_EN = 1'b1;
`else
  localparam logic WRONG_EN = 1'b0;
`endif
  state_t               state, state_d;
  logic [CNT_W-1:0]     cnt, cnt_d;
  logic [IDX_W-1:0]     idx, idx_d, cand_raw, cand_fold, cand;
  logic [N_TARGETS-1:0] sync1, sync2, prev, edges, lit_mask, led_d, hit_d;
  logic                 miss_d, wrong_d, hit_edge, wrong_edge, timeout;
  logic [LFSR_W-1:0]    lfsr;
  logic                 unused_lfsr;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (1'b1),
    .q    (lfsr)
  );

  assign unused_lfsr = ^lfsr[LFSR_W-1:IDX_W];
  assign cand_raw = lfsr[IDX_W-1:0];
  assign cand_fold = (cand_raw >= N_IDX) ? cand_raw - N_IDX : cand_raw;
  assign cand = (cand_fold != idx) ? cand_fold : (cand_fold == LAST_IDX) ? '0 : cand_fold + 1'b1;
  assign lit_mask = ONE << idx;
  assign edges = sync2 ^ prev;
  assign hit_edge = |(edges & lit_mask);
  assign wrong_edge = WRONG_EN & |(edges & ~lit_mask);
  assign timeout = cnt == LIFE_LAST;

  // next state, counter, target and pulse decisions; start beats game_active dropping
  always_comb begin
    state_d = state;
    cnt_d = cnt + 1'b1;
    idx_d = idx;
    led_d = target_led;
    hit_d = '0;
    miss_d = 1'b0;
    wrong_d = 1'b0;
    if (start_pulse) begin
      state_d = GAP;
      cnt_d = '0;
      led_d = '0;
    end else if (!game_active) begin
      state_d = IDLE;
      cnt_d = '0;
      led_d = '0;
    end else begin
      case (state)
        GAP: begin
          if (cnt == GAP_LAST) begin
            state_d = LIT;
            cnt_d = '0;
            idx_d = cand;
            led_d = ONE << cand;
          end
        end
        LIT: begin
          if (hit_edge | wrong_edge | timeout) begin
            state_d = GAP;
            cnt_d = '0;
            led_d = '0;
            hit_d = hit_edge ? lit_mask : '0;
            wrong_d = !hit_edge & wrong_edge;
            miss_d = !hit_edge & !wrong_edge & timeout;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d = '0;
          led_d = '0;
        end
      endcase
    end
  end

  // state, registered outputs and the switch synchroniser / edge-detect chain
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      target_led <= '0;
      hit_pulse <= '0;
      miss_pulse <= 1'b0;
      wrong_pulse <= 1'b0;
      sync1 <= '0;
      sync2 <= '0;
      prev <= '0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      idx <= idx_d;
      target_led <= led_d;
      hit_pulse <= hit_d;
      miss_pulse <= miss_d;
      wrong_pulse <= wrong_d;
      sync1 <= sw_in;
      sync2 <= sync1;
      prev <= sync2;
    end
endmodule

// File: doc/target_engine.md
Name: target_engine

Overview:
Producer side of the hit interface: generates the one-hot `hit_pulse[17:0]` that the score counter consumes.
- Lights one pseudo-random target LED at a time.
- Synchronises and edge-detects the 18 slide switches.
- Emits a single-cycle one-hot hit when the lit target's switch is flipped, and a miss pulse when the target times out.
- Sits between the board switch/LED pins and the score counter; shares `start_pulse` and `game_active` with it.

Parameters:
- N_TARGETS, 18, number of targets/switches/LEDs; must satisfy 2^(IDX_W-1) < N_TARGETS <= 2^IDX_W.
- LIFETIME_CYCLES, 50_000_000, clock cycles a target stays lit before a miss.
- GAP_CYCLES, 12_500_000, clock cycles all LEDs are dark between targets.
- LFSR_SEED, 16'hACE1, LFSR value at reset; must be non-zero.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- start_pulse  input  1  one-cycle game start/restart.
- game_active  input  1  high while a game is running.
- sw_in  input  N_TARGETS  raw asynchronous slide switches.
- target_led  output  N_TARGETS  one-hot lit target, or all zero.
- hit_pulse  output  N_TARGETS  one-cycle one-hot hit at the target index.
- miss_pulse  output  1  one-cycle pulse on target timeout.
- wrong_pulse  output  1  one-cycle pulse on a wrong switch (optional feature only; otherwise tied 0).

Behaviour:
- **Reset** (rst_n low, async):
  - State IDLE.
  - target_led, hit_pulse, miss_pulse, wrong_pulse = 0.
  - Counters = 0.
  - LFSR = LFSR_SEED.
  - Synchroniser and previous-sample regs = 0.
- **Input path:** 2-flop synchroniser per switch, then prev register.
  - edge[i] = sync2[i] ^ prev[i]; both flip directions count.
  - All outputs are registered; hit_pulse rises 3 clk edges after sw_in changes.
- **LFSR:** 16-bit Fibonacci, taps 16,14,13,11; advances every cycle while not in reset.
  - Candidate index = LFSR[IDX_W-1:0], minus N_TARGETS if >= N_TARGETS.
  - If the candidate equals the previous target index, use (candidate+1) mod N_TARGETS.
- **FSM states:** IDLE, GAP, LIT.
  - IDLE: LEDs off, no pulses. start_pulse -> GAP with counter cleared.
  - GAP: counter counts to GAP_CYCLES-1, then -> LIT. On that transition, latch the index, set target_led one-hot, clear the counter.
  - LIT, edge on the lit index: hit_pulse[idx]=1 for one cycle, target_led=0 the same cycle, -> GAP.
  - LIT, counter reaches LIFETIME_CYCLES-1 with no hit: miss_pulse=1 for one cycle, target_led=0, -> GAP.
  - LIT, hit edge and timeout in the same cycle: the hit wins; no miss.
  - LIT, edges on non-lit indices: ignored (see optional feature).
- **Control overrides:**
  - game_active low in any state -> IDLE next cycle. LEDs cleared; any pending pulse is suppressed.
  - start_pulse in any state -> GAP, counter cleared, target_led=0, prev<=sync2 so no spurious edge.
  - start_pulse has priority over game_active deassertion in the same cycle.
  - Edges seen in GAP/IDLE are discarded, never queued.
- **Invariants:**
  - hit_pulse is one-hot or zero.
  - hit_pulse, miss_pulse and wrong_pulse are never high in the same cycle.
  - At most one pulse per target lifetime.
- **Counter width:** clog2(max(LIFETIME_CYCLES, GAP_CYCLES)); no wrap, because it is cleared on every state change.

Optional Feature:
WRONG_HIT_PENALTY_EN
- Defined: in LIT, an edge on any non-lit index with no edge on the lit index gives wrong_pulse=1 for one cycle, target_led=0, -> GAP.
  - If the lit index and another index edge in the same cycle, the hit wins and wrong_pulse stays 0.
  - Timeout together with a wrong edge: wrong wins.
- Undefined: wrong_pulse is constant 0; non-lit edges are ignored.

Decomposition:
- Package target_pkg:
  - state enum (IDLE/GAP/LIT);
  - N_TARGETS default;
  - LFSR width and tap mask;
  - IDX_W derivation function.
- One sub-module, lfsr16: enable, seed parameter, 16-bit state output.
- Synchroniser and edge detect stay inline.

Test Plan (LIFETIME_CYCLES=20, GAP_CYCLES=5, seed 16'hACE1):
1. Reset then start_pulse with game_active=1:
   - all outputs 0 for 5 cycles;
   - then exactly one target_led bit set, index < 18.
2. Flip the sw_in bit matching the lit LED:
   - hit_pulse equals the same one-hot 3 cycles later, for 1 cycle;
   - target_led=0 that cycle; next target lit 5 cycles later, at a different index.
3. No switch activity:
   - miss_pulse high for 1 cycle after 20 lit cycles;
   - hit_pulse stays 0; repeats every 25 cycles.
4. Flip the lit switch timed so its edge lands on the timeout cycle:
   - hit_pulse asserted, miss_pulse 0.
5. Flip a non-lit switch during LIT:
   - no pulse and LED unchanged without the macro;
   - with WRONG_HIT_PENALTY_EN, wrong_pulse 1 cycle and LED cleared.
6. Control overrides:
   - Deassert game_active mid-LIT: LEDs 0 next cycle, no pulses.
   - Assert rst_n=0 mid-LIT: all outputs 0 immediately.
   - start_pulse while a switch is held flipped: no spurious hit.
